// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one single-port 16-bit block RAM between fetch (A) and load/store (B).
// Latency: grant is combinational in the request cycle; read data and error responses follow one cycle later.
// Backpressure: a losing requester holds req and is granted next cycle; out-of-range accesses get an error response.
module bram_arbiter #(
  parameter int bits = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [15:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [15:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [15:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [15:0] b_rdata,
  output logic        b_err,
  output logic        mem_wren_n,
  output logic        mem_oen_n,
  output logic [15:0] mem_address,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out
);

  // last = 1 means B was granted most recently; reset to B so A wins the first contention
  logic        last;
  logic        gnt_any;
  logic        g_we;
  logic        g_oor;
  logic        g_acc;
  logic [15:0] g_addr;
  logic [15:0] g_wdata;
  logic        rsp_valid;
  logic        rsp_port;
  logic        rsp_err;

  // Grants: a lone requester always wins; on contention the port not granted last wins
  assign a_gnt   = rst_n & a_req & (~b_req | last);
  assign b_gnt   = rst_n & b_req & (~a_req | ~last);
  assign gnt_any = a_gnt | b_gnt;

  // Granted port's request fields
  assign g_addr  = b_gnt ? b_addr  : a_addr;
  assign g_wdata = b_gnt ? b_wdata : a_wdata;
  assign g_we    = b_gnt ? b_we    : a_we;
  assign g_oor   = |(g_addr >> bits);
  assign g_acc   = gnt_any & ~g_oor;

  // RAM drive is only active for an in-range grant; otherwise the bus rests at zero
  assign mem_oen_n   = ~(g_acc & ~g_we);
  assign mem_wren_n  = ~(g_acc & g_we);
  assign mem_address = g_acc ? g_addr  : 16'h0000;
  assign mem_data_in = g_acc ? g_wdata : 16'h0000;

  // Priority register moves only when somebody is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (gnt_any) begin
      last <= b_gnt;
    end
  end

  // Response pipeline: reads and all out-of-range accesses respond next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_port  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= gnt_any & (g_oor | ~g_we);
      rsp_port  <= b_gnt;
      rsp_err   <= g_oor;
    end
  end

  // Steer the response; RAM data passes straight through, errors return zero
  assign a_rvalid = rsp_valid & ~rsp_port;
  assign b_rvalid = rsp_valid & rsp_port;
  assign a_err    = a_rvalid & rsp_err;
  assign b_err    = b_rvalid & rsp_err;
  assign a_rdata  = (a_rvalid & ~rsp_err) ? mem_data_out : 16'h0000;
  assign b_rdata  = (b_rvalid & ~rsp_err) ? mem_data_out : 16'h0000;

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter with a behavioural registered-read RAM.
// Stimulus issues one directed vector per cycle and queues expected responses.
// A monitor compares both response ports every cycle against the queue.
module tb_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [15:0] a_addr = '0, a_wdata = '0;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [15:0] b_addr = '0, b_wdata = '0;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [15:0] a_rdata, b_rdata;
  logic        mem_wren_n, mem_oen_n;
  logic [15:0] mem_address, mem_data_in;
  logic [15:0] mem_data_out = '0;

  logic [15:0] ram [0:1023];

  typedef struct {
    int          due;
    logic        port;
    logic        err;
    logic [15:0] data;
  } rsp_t;

  rsp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  bram_arbiter #(.bits(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .mem_wren_n(mem_wren_n), .mem_oen_n(mem_oen_n),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM model with registered read data
  always @(posedge clk) begin
    if (!mem_wren_n) ram[mem_address[9:0]] <= mem_data_in;
    if (!mem_oen_n) mem_data_out <= ram[mem_address[9:0]];
  end

  // Monitor: every cycle both response ports must match the queued expectation (or be idle)
  logic [35:0] m_exp, m_act;
  rsp_t        m_r;
  always @(negedge clk) begin
    m_exp = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      m_r = q.pop_front();
      if (m_r.port) m_exp = {1'b0, 1'b0, 16'h0000, 1'b1, m_r.err, m_r.data};
      else          m_exp = {1'b1, m_r.err, m_r.data, 1'b0, 1'b0, 16'h0000};
    end
    m_act = {a_rvalid, a_err, a_rdata, b_rvalid, b_err, b_rdata};
    checks++;
    if (m_act !== m_exp) begin
      errors++;
      $display("FAIL rsp cycle %0d: got a(v=%b e=%b d=%h) b(v=%b e=%b d=%h) want a(v=%b e=%b d=%h) b(v=%b e=%b d=%h)",
               cyc, m_act[35], m_act[34], m_act[33:18], m_act[17], m_act[16], m_act[15:0],
               m_exp[35], m_exp[34], m_exp[33:18], m_exp[17], m_exp[16], m_exp[15:0]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // One cycle of stimulus: drive inputs, check combinational outputs, queue the response
  task automatic step(
    input logic rst,
    input logic ar, input logic aw, input logic [15:0] aa, input logic [15:0] ad,
    input logic br, input logic bw, input logic [15:0] ba, input logic [15:0] bd,
    input logic eag, input logic ebg, input logic ewr_n, input logic eoe_n,
    input logic [15:0] eaddr,
    input logic rsp, input logic rerr, input logic [15:0] rdata);
    rsp_t r;
    logic [15:0] edin;
    @(posedge clk);
    #1;
    rst_n = rst;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    @(negedge clk);
    edin = (!ewr_n || !eoe_n) ? (eag ? ad : bd) : 16'h0000;
    chk("gnt", {30'd0, a_gnt, b_gnt}, {30'd0, eag, ebg});
    chk("strobes", {30'd0, mem_wren_n, mem_oen_n}, {30'd0, ewr_n, eoe_n});
    chk("mem_address", {16'd0, mem_address}, {16'd0, eaddr});
    chk("mem_data_in", {16'd0, mem_data_in}, {16'd0, edin});
    if (rsp) begin
      r.due = cyc + 1; r.port = ebg; r.err = rerr; r.data = rdata;
      q.push_back(r);
    end
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) ram[k] = 16'hA000 + k[15:0];

    // Reset held with both requesting: nothing granted, RAM idle
    step(0, 1,0,16'h0001,0, 1,0,16'h0002,0, 0,0, 1,1,16'h0000, 0,0,0);
    step(0, 1,0,16'h0001,0, 1,0,16'h0002,0, 0,0, 1,1,16'h0000, 0,0,0);
    // Release with both still requesting: A, B, A
    step(1, 1,0,16'h0001,0, 1,0,16'h0002,0, 1,0, 1,0,16'h0001, 1,0,16'hA001);
    step(1, 1,0,16'h0001,0, 1,0,16'h0002,0, 0,1, 1,0,16'h0002, 1,0,16'hA002);
    step(1, 1,0,16'h0001,0, 1,0,16'h0002,0, 1,0, 1,0,16'h0001, 1,0,16'hA001);
    // Write then read on A, back-to-back
    step(1, 1,1,16'h0012,16'hBEEF, 0,0,0,0, 1,0, 0,1,16'h0012, 0,0,0);
    step(1, 1,0,16'h0012,0,        0,0,0,0, 1,0, 1,0,16'h0012, 1,0,16'hBEEF);
    // Lone B read leaves B as last winner
    step(1, 0,0,0,0, 1,0,16'h0003,0, 0,1, 1,0,16'h0003, 1,0,16'hA003);
    // Contention: A,B,A,B,A,B
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        step(1, 1,0,16'h0001,0, 1,0,16'h0002,0, 1,0, 1,0,16'h0001, 1,0,16'hA001);
      else
        step(1, 1,0,16'h0001,0, 1,0,16'h0002,0, 0,1, 1,0,16'h0002, 1,0,16'hA002);
    end
    // Out of range: B read 0x0400 errors; A read in the next cycle proceeds normally
    step(1, 0,0,0,0, 1,0,16'h0400,0, 0,1, 1,1,16'h0000, 1,1,16'h0000);
    step(1, 1,0,16'h0005,0, 0,0,0,0, 1,0, 1,0,16'h0005, 1,0,16'hA005);
    // Out-of-range write also errors and does not strobe the RAM
    step(1, 1,1,16'hFFFF,16'h1234, 0,0,0,0, 1,0, 1,1,16'h0000, 1,1,16'h0000);
    // Back-to-back A reads 0..3
    for (int i = 0; i < 4; i++)
      step(1, 1,0,i[15:0],0, 0,0,0,0, 1,0, 1,0,i[15:0], 1,0,16'hA000 + i[15:0]);
    // Idle cycle
    step(1, 0,0,0,0, 0,0,0,0, 0,0, 1,1,16'h0000, 0,0,0);
    // Reset in the cycle after an A read grant: response is dropped
    step(1, 1,0,16'h0012,0, 0,0,0,0, 1,0, 1,0,16'h0012, 0,0,0);
    step(0, 0,0,0,0, 0,0,0,0, 0,0, 1,1,16'h0000, 0,0,0);
    // After reset the earlier write is still in memory
    step(1, 1,0,16'h0012,0, 0,0,0,0, 1,0, 1,0,16'h0012, 1,0,16'hBEEF);
    step(1, 0,0,0,0, 0,0,0,0, 0,0, 1,1,16'h0000, 0,0,0);
    step(1, 0,0,0,0, 0,0,0,0, 0,0, 1,1,16'h0000, 0,0,0);

    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
